tdm_slot_demux: RTL and testbench
=================================

Name: tdm_slot_demux

Overview:
- Receive end of the three-source time-division link. The upstream mux produces one 8-bit data/valid stream; each source owns a fixed window of a repeating down-counter frame.
- This block runs an identical frame counter, decodes which source owns each received word, and steers the word into one of three per-channel FIFOs.
- Each FIFO drains through a valid/ready handshake to a downstream consumer.

Parameters:
- PERIOD, 15, frame length minus 1. Counter counts PERIOD..0, then wraps to PERIOD.
- THR_ONE, 10, count > THR_ONE selects channel 1.
- THR_TWO, 5, count > THR_TWO (and not above) selects channel 2.
- THR_THREE, 0, count > THR_THREE (and not above) selects channel 3; at or below is the guard window.
- LATENCY, 1, cycles between the transmitter's counter and its data appearing on in_data (1..4).
- DEPTH, 4, entries per channel FIFO (power of 2, at least 2).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  received TDM word.
- in_valid  in  1  in_data qualifier.
- out_data  out  24  channel n head word at bits [8n-1:8n-8], n=1..3.
- out_valid  out  3  bit n-1 high means FIFO n is non-empty.
- out_ready  in  3  bit n-1 pops FIFO n when out_valid[n-1] is also high.
- overflow  out  3  sticky, set when a word for channel n is dropped because FIFO n is full.
- guard_err  out  1  sticky, set when in_valid is high during the guard window.
- clear_err  in  1  synchronous clear of overflow and guard_err.

Behaviour:
- Reset (reset=0, async):
  - frame counter = PERIOD; delay line cleared.
  - All FIFOs empty; out_valid=0, out_data=0, overflow=0, guard_err=0.
- Frame counter:
  - Decrements every cycle; at 0, reloads PERIOD on the next edge.
  - Width is clog2(PERIOD)+1.
  - Identical to the transmitter counter, so alignment holds when both leave reset on the same edge.
- Slot decode:
  - Uses the counter delayed by LATENCY cycles through a shift register.
  - For the first LATENCY cycles after reset the delayed value is invalid; in_valid is ignored then (no push, no error).
  - Decode priority: > THR_ONE → ch1; else > THR_TWO → ch2; else > THR_THREE → ch3; else guard.
- Push: on an edge with in_valid=1 and decoded channel n, in_data is written to FIFO n.
  - out_valid[n-1] rises the cycle after the write edge, so ingress-to-egress latency is 1 cycle.
- Pop: on an edge with out_valid[n-1]=1 and out_ready[n-1]=1.
  - out_data slice advances to the next entry in the same cycle it updates.
  - When empty, the out_data slice holds its last value.
- Full FIFO:
  - Push with no pop: word dropped, overflow[n-1] set.
  - Simultaneous push and pop: both happen, no drop, occupancy unchanged.
- Empty FIFO with push and out_ready high: no bypass. The word is visible the next cycle.
- Guard window:
  - in_valid=1 sets guard_err; the word is discarded.
  - in_valid=0 in guard is normal.
- Error clear:
  - clear_err=1 clears the sticky bits on the edge.
  - If a new error event occurs on the same edge, that bit stays set (set wins).
- Errors never alter the counter or FIFO contents.
- Reset mid-frame: asserting reset at any time empties the FIFOs (stored words are lost) and restarts the counter at PERIOD.
- in_data is ignored whenever in_valid=0.

Optional Feature:
- Macro: TDM_SLOT_DEMUX_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt [23:0]: three 8-bit counters, channel n at bits [8n-1:8n-8].
  - A counter increments on each overflow drop for its channel and saturates at 255.
  - Reset to 0; cleared by clear_err (an increment on the same edge wins, giving a value of 1).
- When undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic steering:
  - Stimulus: release reset, hold out_ready=3'b111, in_valid=1, in_data=counter-tagged values.
  - Required response:
    - Delayed count 15..11 lands on ch1, 10..6 on ch2, 5..1 on ch3.
    - Words arrive in order, 1 cycle after ingress.
    - Delayed count 0 sets guard_err=1.
- Latency alignment:
  - Stimulus: LATENCY=2, in_valid=1 from the first cycle after reset.
  - Required response: the first 2 cycles are not pushed and guard_err stays 0; steering matches the transmitter's counter value 2 cycles earlier.
- Overflow:
  - Stimulus: out_ready=0, five valid ch1 words 0xA1..0xA5.
  - Required response: FIFO1 holds 0xA1..0xA4, 0xA5 is dropped, overflow=3'b001; with the optional macro, drop_cnt[7:0]=1.
- Full with simultaneous push/pop:
  - Stimulus: FIFO2 full, out_ready[1]=1 on the same edge as a ch2 push of 0xB5.
  - Required response: 0xB1 is popped, 0xB5 is stored, overflow[1] stays 0.
- Clear versus set:
  - Stimulus: clear_err=1 on the same edge as a guard-window push.
  - Required response: guard_err stays 1. clear_err on a quiet edge clears guard_err to 0 and overflow to 0.
- Async reset mid-frame:
  - Stimulus: drive reset=0 between edges with words queued in all FIFOs.
  - Required response: out_valid=0 immediately; after release, the counter restarts at 15.

Source files
------------

// File: rtl/tdm_slot_demux.sv
// tdm_slot_demux: receive side of the three-source TDM link. Recreates the
// transmitter's frame counter, decodes slot ownership from the counter delayed
// by LATENCY, and steers each valid word into one of three per-channel FIFOs
// that drain through valid/ready. Defining TDM_SLOT_DEMUX_DROP_CNT_EN adds
// saturating per-channel drop counters on the drop_cnt port.
module tdm_slot_demux #(
    parameter int PERIOD    = 15,
    parameter int THR_ONE   = 10,
    parameter int THR_TWO   = 5,
    parameter int THR_THREE = 0,
    parameter int LATENCY   = 1,
    parameter int DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic [23:0] out_data,
    output logic [2:0]  out_valid,
    input  logic [2:0]  out_ready,
    output logic [2:0]  overflow,
    output logic        guard_err,
    input  logic        clear_err
`ifdef TDM_SLOT_DEMUX_DROP_CNT_EN
    ,
    output logic [23:0] drop_cnt
`endif
);
    localparam int CW = $clog2(PERIOD) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] P  = CW'(PERIOD);
    localparam logic [CW-1:0] T1 = CW'(THR_ONE);
    localparam logic [CW-1:0] T2 = CW'(THR_TWO);
    localparam logic [CW-1:0] T3 = CW'(THR_THREE);

    logic [CW-1:0]      count;
    logic [CW-1:0]      dly [LATENCY];
    logic [LATENCY-1:0] dly_v;
    logic [CW-1:0]      slot;
    logic               live;
    logic [2:0]         wr;
    logic [2:0]         drop;
    logic               guard_ev;

    // frame counter plus the delay line that realigns it with the received words
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= P;
            dly_v <= '0;
            for (int i = 0; i < LATENCY; i++) dly[i] <= '0;
        end else begin
            count    <= (count == '0) ? P : count - 1'b1;
            dly[0]   <= count;
            dly_v[0] <= 1'b1;
            for (int i = 1; i < LATENCY; i++) begin
                dly[i]   <= dly[i-1];
                dly_v[i] <= dly_v[i-1];
            end
        end
    end

    assign slot     = dly[LATENCY-1];
    assign live     = dly_v[LATENCY-1] & in_valid;
    assign wr[0]    = live & (slot > T1);
    assign wr[1]    = live & (slot <= T1) & (slot > T2);
    assign wr[2]    = live & (slot <= T2) & (slot > T3);
    assign guard_ev = live & (slot <= T3);

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_ch
            logic [7:0]  mem [DEPTH];
            logic [AW-1:0] wp, rp;
            logic [AW:0] cnt;
            logic [7:0]  hold;
            logic        empty, full, push, pop;

            assign empty   = (cnt == '0);
            assign full    = (cnt == (AW+1)'(DEPTH));
            assign pop     = !empty & out_ready[g];
            assign push    = wr[g] & (!full | pop);
            assign drop[g] = wr[g] & full & !pop;
            assign out_valid[g]      = !empty;
            assign out_data[8*g +: 8] = empty ? hold : mem[rp];

            // storage array; a push into a full FIFO with a pop reuses the head slot
            always_ff @(posedge clock) begin
                if (push) mem[wp] <= in_data;
            end

            // pointers, occupancy and the last-popped word shown while empty
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    wp   <= '0;
                    rp   <= '0;
                    cnt  <= '0;
                    hold <= '0;
                end else begin
                    wp   <= wp + AW'(push);
                    rp   <= rp + AW'(pop);
                    cnt  <= cnt + (AW+1)'(push) - (AW+1)'(pop);
                    hold <= pop ? mem[rp] : hold;
                end
            end

`ifdef TDM_SLOT_DEMUX_DROP_CNT_EN
            logic [7:0] dcnt;
            assign drop_cnt[8*g +: 8] = dcnt;

            // saturating drop counter; a drop on a clearing edge leaves a count of one
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) dcnt <= '0;
                else dcnt <= drop[g] ? (clear_err ? 8'd1 : (&dcnt ? dcnt : dcnt + 8'd1))
                                     : (clear_err ? 8'd0 : dcnt);
            end
`endif
        end
    endgenerate

    // sticky error flags; a new event on a clearing edge keeps its bit set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow  <= '0;
            guard_err <= 1'b0;
        end else begin
            overflow  <= (overflow & ~{3{clear_err}}) | drop;
            guard_err <= (guard_err & ~clear_err) | guard_ev;
        end
    end
endmodule

// File: tb/tb_tdm_slot_demux.sv
// tb_tdm_slot_demux: directed bench for tdm_slot_demux (LATENCY 1 and 2 instances)
module tb_tdm_slot_demux;
    logic        clock, reset;
    logic [7:0]  in_data, in2_data;
    logic        in_valid, in2_valid, clear_err, clear2;
    logic [2:0]  out_ready, out2_ready;
    logic [23:0] out_data, out2_data;
    logic [2:0]  out_valid, out2_valid, overflow, overflow2;
    logic        guard_err, guard2;
`ifdef TDM_SLOT_DEMUX_DROP_CNT_EN
    logic [23:0] drop_cnt, drop_cnt2;
`endif
    int n_cmp = 0;
    int n_err = 0;

    tdm_slot_demux u_dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .guard_err(guard_err), .clear_err(clear_err)
`ifdef TDM_SLOT_DEMUX_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    tdm_slot_demux #(.LATENCY(2)) u_lat2 (
        .clock(clock), .reset(reset), .in_data(in2_data), .in_valid(in2_valid),
        .out_data(out2_data), .out_valid(out2_valid), .out_ready(out2_ready),
        .overflow(overflow2), .guard_err(guard2), .clear_err(clear2)
`ifdef TDM_SLOT_DEMUX_DROP_CNT_EN
        , .drop_cnt(drop_cnt2)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        in_valid = 0; in_data = 0; out_ready = 0; clear_err = 0;
        in2_valid = 0; in2_data = 0; out2_ready = 0; clear2 = 0;
        reset = 0;
        step;
        step;
        reset = 1;
    endtask

    task automatic test_reset;
        in_valid = 0; in_data = 0; out_ready = 0; clear_err = 0;
        in2_valid = 0; in2_data = 0; out2_ready = 0; clear2 = 0;
        reset = 0;
        #3;
        n_cmp++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL reset_valid got %b want 000", out_valid); end
        n_cmp++; if (out_data !== 24'h0) begin n_err++; $display("FAIL reset_data got %h want 000000", out_data); end
        n_cmp++; if (overflow !== 3'b000) begin n_err++; $display("FAIL reset_overflow got %b want 000", overflow); end
        n_cmp++; if (guard_err !== 1'b0) begin n_err++; $display("FAIL reset_guard got %b want 0", guard_err); end
        n_cmp++; if (out2_valid !== 3'b000) begin n_err++; $display("FAIL reset_valid2 got %b want 000", out2_valid); end
`ifdef TDM_SLOT_DEMUX_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 24'h0) begin n_err++; $display("FAIL reset_dropcnt got %h want 000000", drop_cnt); end
`endif
    endtask

    task automatic test_steering;
        int ch;
        logic [2:0] ev;
        do_reset;
        out_ready = 3'b111;
        in_valid = 1;
        for (int c = 0; c <= 16; c++) begin
            in_data = 8'h40 + 8'(c);
            step;
            ch = (c == 0 || c == 16) ? 0 : (c <= 5) ? 1 : (c <= 10) ? 2 : 3;
            ev = (ch == 0) ? 3'b000 : 3'(1 << (ch - 1));
            n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL steer_valid c=%0d got %b want %b", c, out_valid, ev); end
            if (ch != 0) begin
                n_cmp++;
                if (out_data[8*(ch-1) +: 8] !== 8'h40 + 8'(c)) begin
                    n_err++; $display("FAIL steer_data c=%0d got %h want %h", c, out_data[8*(ch-1) +: 8], 8'h40 + 8'(c));
                end
            end
            n_cmp++; if (guard_err !== (c == 16)) begin n_err++; $display("FAIL steer_guard c=%0d got %b want %b", c, guard_err, c == 16); end
        end
        n_cmp++; if (out_data[23:16] !== 8'h4F) begin n_err++; $display("FAIL steer_hold3 got %h want 4f", out_data[23:16]); end
        n_cmp++; if (out_data[7:0] !== 8'h45) begin n_err++; $display("FAIL steer_hold1 got %h want 45", out_data[7:0]); end
        in_valid = 0;
    endtask

    task automatic test_latency;
        logic [2:0] ev;
        do_reset;
        out2_ready = 3'b111;
        in2_valid = 1;
        for (int c = 0; c <= 7; c++) begin
            in2_data = 8'h60 + 8'(c);
            step;
            ev = (c < 2) ? 3'b000 : (c <= 6) ? 3'b001 : 3'b010;
            n_cmp++; if (out2_valid !== ev) begin n_err++; $display("FAIL lat2_valid c=%0d got %b want %b", c, out2_valid, ev); end
            n_cmp++; if (guard2 !== 1'b0) begin n_err++; $display("FAIL lat2_guard c=%0d got %b want 0", c, guard2); end
            if (c >= 2) begin
                n_cmp++;
                if (out2_data[(c <= 6 ? 0 : 8) +: 8] !== 8'h60 + 8'(c)) begin
                    n_err++; $display("FAIL lat2_data c=%0d got %h want %h", c, out2_data[(c <= 6 ? 0 : 8) +: 8], 8'h60 + 8'(c));
                end
            end
        end
        in2_valid = 0;
    endtask

    task automatic test_overflow;
        do_reset;
        for (int c = 0; c <= 5; c++) begin
            in_valid = (c >= 1);
            in_data = 8'hA0 + 8'(c);
            step;
            if (c == 4) begin
                n_cmp++; if (overflow !== 3'b000) begin n_err++; $display("FAIL ovf_early got %b want 000", overflow); end
            end
        end
        n_cmp++; if (overflow !== 3'b001) begin n_err++; $display("FAIL ovf_flag got %b want 001", overflow); end
        n_cmp++; if (out_valid !== 3'b001) begin n_err++; $display("FAIL ovf_valid got %b want 001", out_valid); end
        n_cmp++; if (out_data[7:0] !== 8'hA1) begin n_err++; $display("FAIL ovf_head got %h want a1", out_data[7:0]); end
`ifdef TDM_SLOT_DEMUX_DROP_CNT_EN
        n_cmp++; if (drop_cnt[7:0] !== 8'd1) begin n_err++; $display("FAIL ovf_dropcnt got %0d want 1", drop_cnt[7:0]); end
`endif
        in_valid = 0;
        out_ready = 3'b001;
        for (int k = 2; k <= 4; k++) begin
            step;
            n_cmp++; if (out_data[7:0] !== 8'hA0 + 8'(k)) begin n_err++; $display("FAIL ovf_drain k=%0d got %h want %h", k, out_data[7:0], 8'hA0 + 8'(k)); end
        end
        step;
        n_cmp++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL ovf_empty got %b want 000", out_valid); end
        n_cmp++; if (out_data[7:0] !== 8'hA4) begin n_err++; $display("FAIL ovf_hold got %h want a4", out_data[7:0]); end
        n_cmp++; if (overflow !== 3'b001) begin n_err++; $display("FAIL ovf_sticky got %b want 001", overflow); end
    endtask

    task automatic test_full_pushpop;
        do_reset;
        for (int c = 0; c <= 10; c++) begin
            in_valid = (c >= 6);
            in_data = 8'hB0 + 8'(c - 5);
            out_ready = (c == 10) ? 3'b010 : 3'b000;
            step;
        end
        n_cmp++; if (overflow !== 3'b000) begin n_err++; $display("FAIL pp_overflow got %b want 000", overflow); end
        n_cmp++; if (out_valid !== 3'b010) begin n_err++; $display("FAIL pp_valid got %b want 010", out_valid); end
        n_cmp++; if (out_data[15:8] !== 8'hB2) begin n_err++; $display("FAIL pp_head got %h want b2", out_data[15:8]); end
        in_valid = 0;
        out_ready = 3'b010;
        for (int k = 3; k <= 5; k++) begin
            step;
            n_cmp++; if (out_data[15:8] !== 8'hB0 + 8'(k)) begin n_err++; $display("FAIL pp_drain k=%0d got %h want %h", k, out_data[15:8], 8'hB0 + 8'(k)); end
        end
        step;
        n_cmp++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL pp_empty got %b want 000", out_valid); end
    endtask

    task automatic test_clear;
        do_reset;
        for (int c = 0; c <= 19; c++) begin
            in_valid = (c >= 1 && c <= 5) || c == 16 || c == 17 || c == 19;
            in_data = 8'hC0 + 8'(c);
            clear_err = (c == 16 || c == 18 || c == 19);
            step;
            if (c == 5) begin
                n_cmp++; if (overflow !== 3'b001) begin n_err++; $display("FAIL clr_ovf5 got %b want 001", overflow); end
            end
            if (c == 16) begin
                n_cmp++; if (guard_err !== 1'b1) begin n_err++; $display("FAIL clr_guard_setwins got %b want 1", guard_err); end
                n_cmp++; if (overflow !== 3'b000) begin n_err++; $display("FAIL clr_ovf16 got %b want 000", overflow); end
            end
            if (c == 17) begin
                n_cmp++; if (overflow !== 3'b001) begin n_err++; $display("FAIL clr_ovf17 got %b want 001", overflow); end
                n_cmp++; if (guard_err !== 1'b1) begin n_err++; $display("FAIL clr_guard17 got %b want 1", guard_err); end
`ifdef TDM_SLOT_DEMUX_DROP_CNT_EN
                n_cmp++; if (drop_cnt[7:0] !== 8'd1) begin n_err++; $display("FAIL clr_dc17 got %0d want 1", drop_cnt[7:0]); end
`endif
            end
            if (c == 18) begin
                n_cmp++; if (guard_err !== 1'b0) begin n_err++; $display("FAIL clr_guard_quiet got %b want 0", guard_err); end
                n_cmp++; if (overflow !== 3'b000) begin n_err++; $display("FAIL clr_ovf_quiet got %b want 000", overflow); end
`ifdef TDM_SLOT_DEMUX_DROP_CNT_EN
                n_cmp++; if (drop_cnt[7:0] !== 8'd0) begin n_err++; $display("FAIL clr_dc18 got %0d want 0", drop_cnt[7:0]); end
`endif
            end
        end
        n_cmp++; if (overflow !== 3'b001) begin n_err++; $display("FAIL clr_ovf_setwins got %b want 001", overflow); end
`ifdef TDM_SLOT_DEMUX_DROP_CNT_EN
        n_cmp++; if (drop_cnt[7:0] !== 8'd1) begin n_err++; $display("FAIL clr_dc19 got %0d want 1", drop_cnt[7:0]); end
`endif
        n_cmp++; if (out_valid !== 3'b001) begin n_err++; $display("FAIL clr_fifo_valid got %b want 001", out_valid); end
        n_cmp++; if (out_data[7:0] !== 8'hC1) begin n_err++; $display("FAIL clr_fifo_head got %h want c1", out_data[7:0]); end
        in_valid = 0;
        clear_err = 0;
    endtask

    task automatic test_async_reset;
        do_reset;
        for (int c = 0; c <= 11; c++) begin
            in_valid = (c == 1 || c == 6 || c == 11);
            in_data = 8'hD0 + 8'(c);
            step;
        end
        n_cmp++; if (out_valid !== 3'b111) begin n_err++; $display("FAIL ar_queued got %b want 111", out_valid); end
        in_valid = 0;
        #3;
        reset = 0;
        #1;
        n_cmp++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL ar_valid got %b want 000", out_valid); end
        n_cmp++; if (out_data !== 24'h0) begin n_err++; $display("FAIL ar_data got %h want 000000", out_data); end
        @(posedge clock);
        #1;
        reset = 1;
        out_ready = 3'b111;
        for (int c = 0; c <= 6; c++) begin
            in_valid = (c >= 1);
            in_data = 8'hE0 + 8'(c);
            step;
            if (c == 0) begin
                n_cmp++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL ar_c0 got %b want 000", out_valid); end
            end
            if (c == 5) begin
                n_cmp++; if (out_valid !== 3'b001) begin n_err++; $display("FAIL ar_c5 got %b want 001", out_valid); end
                n_cmp++; if (out_data[7:0] !== 8'hE5) begin n_err++; $display("FAIL ar_c5_data got %h want e5", out_data[7:0]); end
            end
            if (c == 6) begin
                n_cmp++; if (out_valid !== 3'b010) begin n_err++; $display("FAIL ar_c6 got %b want 010", out_valid); end
                n_cmp++; if (out_data[15:8] !== 8'hE6) begin n_err++; $display("FAIL ar_c6_data got %h want e6", out_data[15:8]); end
            end
        end
        in_valid = 0;
    endtask

    initial begin
        test_reset;
        test_steering;
        test_latency;
        test_overflow;
        test_full_pushpop;
        test_clear;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
